// File: rtl/aes_decrypt_core_pkg.sv
// Shared AES-128 constants, state encodings and inverse-cipher datapath helpers.
package aes_decrypt_core_pkg;

  localparam int unsigned AES_NR  = 10;
  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned ROUND_W = 4;

  // GF(2^8) reduction constant for x^8 + x^4 + x^3 + x + 1
  localparam logic [7:0] XTIME_POLY = 8'h1b;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_INIT       = 3'd1,
    S_ROUND      = 3'd2,
    S_LAST_ROUND = 3'd3,
    S_FINISH     = 3'd4
  } state_t;

  // Element [15] is byte 0 (bits [127:120]); byte n is row n%4, column n/4
  typedef logic [15:0][7:0] block_t;

  // Forward S-box, entry 0 in the top byte
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Inverse S-box, entry 0 in the top byte
  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Entry b sits at bit offset 8*(255-b), i.e. {~b, 3'b000}
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

  // Row r rotates right by r: out[r][c] = in[r][(c - r) mod 4]
  function automatic block_t inv_shift_rows(input block_t s);
    block_t o;
    o = '0;
    for (int unsigned n = 0; n < 16; n++) begin
      o[4'(15 - n)] = s[4'(15 - ((((n / 4) + 4 - (n % 4)) % 4) * 4 + (n % 4)))];
    end
    return o;
  endfunction

  function automatic block_t inv_sub_bytes(input block_t s);
    block_t o;
    o = '0;
    for (int unsigned n = 0; n < 16; n++) begin
      o[4'(n)] = inv_sbox(s[4'(n)]);
    end
    return o;
  endfunction

  // Multiply by 0e/0b/0d/09 (sel 0..3) using a shared xtime chain
  function automatic logic [7:0] inv_mix_mul(input logic [7:0] a, input logic [1:0] sel);
    logic [7:0] a2, a4, a8, r;
    a2 = xtime(a);
    a4 = xtime(a2);
    a8 = xtime(a4);
    case (sel)
      2'd0:    r = a8 ^ a4 ^ a2;
      2'd1:    r = a8 ^ a2 ^ a;
      2'd2:    r = a8 ^ a4 ^ a;
      default: r = a8 ^ a;
    endcase
    return r;
  endfunction

  // Circulant matrix {0e,0b,0d,09} applied to each column
  function automatic block_t inv_mix_columns(input block_t s);
    block_t o;
    logic [7:0] acc;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int unsigned j = 0; j < 4; j++) begin
          acc = acc ^ inv_mix_mul(s[4'(15 - 4 * c - j)], 2'((j + 4 - r) % 4));
        end
        o[4'(15 - 4 * c - r)] = acc;
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_decrypt_core_key_expansion.sv
// Combinational AES-128 key schedule: returns the round key for any round index 0..10.
module aes_decrypt_core_key_expansion
  import aes_decrypt_core_pkg::*;
(
  input  logic [BLOCK_W-1:0] key,
  input  logic [ROUND_W-1:0] round,
  output logic [BLOCK_W-1:0] rk
);

  logic [BLOCK_W-1:0] k;
  logic [7:0]         rc;

  function automatic logic [BLOCK_W-1:0] next_key(input logic [BLOCK_W-1:0] kin,
                                                  input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = kin[127:96];
    w1 = kin[95:64];
    w2 = kin[63:32];
    w3 = kin[31:0];
    t  = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Unrolled schedule; the requested round's key is tapped off the chain
  always_comb begin
    k  = key;
    rc = 8'h01;
    rk = key;
    for (int unsigned i = 1; i <= AES_NR; i++) begin
      k  = next_key(k, rc);
      rc = xtime(rc);
      if (round == ROUND_W'(i)) rk = k;
    end
  end

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher, one round per clock, start/done handshake.
module aes_decrypt_core
  import aes_decrypt_core_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BLOCK_W-1:0] ciphertext,
  input  logic [BLOCK_W-1:0] key,
  output logic               busy,
  output logic               done,
  output logic [BLOCK_W-1:0] plaintext
);

  state_t             state;
  logic [ROUND_W-1:0] round_cnt;
  block_t             state_reg;
  logic [BLOCK_W-1:0] key_reg;
  logic [BLOCK_W-1:0] rk;
  block_t             inv_core;
  block_t             last_out;
  block_t             round_out;

  // Round key follows round_cnt: 10 in INIT, 9..1 in ROUND, 0 in LAST_ROUND
  aes_decrypt_core_key_expansion u_key_expansion (
    .key   (key_reg),
    .round (round_cnt),
    .rk    (rk)
  );

  assign inv_core  = inv_sub_bytes(inv_shift_rows(state_reg));
  assign last_out  = inv_core ^ rk;
  assign round_out = inv_mix_columns(last_out);

  // Control FSM and round datapath; all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      round_cnt <= '0;
      state_reg <= '0;
      key_reg   <= '0;
      plaintext <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state_reg <= ciphertext;
            key_reg   <= key;
            round_cnt <= ROUND_W'(AES_NR);
            busy      <= 1'b1;
            state     <= S_INIT;
          end
        end
        S_INIT: begin
          state_reg <= state_reg ^ rk;
          round_cnt <= round_cnt - ROUND_W'(1);
          state     <= S_ROUND;
        end
        S_ROUND: begin
          state_reg <= round_out;
          round_cnt <= round_cnt - ROUND_W'(1);
          if (round_cnt == ROUND_W'(1)) state <= S_LAST_ROUND;
        end
        S_LAST_ROUND: begin
          state_reg <= last_out;
          state     <= S_FINISH;
        end
        S_FINISH: begin
          plaintext <= state_reg;
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Self-checking bench for aes_decrypt_core against a byte-level AES reference model.
module tb_aes_decrypt_core;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] ciphertext = '0;
  logic [127:0] key = '0;
  logic         busy;
  logic         done;
  logic [127:0] plaintext;

  aes_decrypt_core dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ciphertext (ciphertext),
    .key        (key),
    .busy       (busy),
    .done       (done),
    .plaintext  (plaintext)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int done_count = 0;
  logic [127:0] exp_q [$];
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- reference model: plain GF(2^8) arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  // S-box = affine(multiplicative inverse); inverse table by reversal
  task automatic build_tables();
    logic [7:0] inv, v;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      v = inv ^ rotl8(inv) ^ rotl8(rotl8(inv)) ^ rotl8(rotl8(rotl8(inv)))
          ^ rotl8(rotl8(rotl8(rotl8(inv)))) ^ 8'h63;
      sb[x]  = v;
      isb[v] = 8'(x);
    end
  endtask

  function automatic logic [127:0] rk_model(input logic [127:0] k, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = 32'(k >> (32 * (3 - i)));
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] enc_model(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] kk, out;
    for (int i = 0; i < 16; i++) s[i] = 8'(pt >> (8 * (15 - i)));
    kk = rk_model(k, 0);
    for (int i = 0; i < 16; i++) s[i] ^= 8'(kk >> (8 * (15 - i)));
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r + 4*c] = s[r + 4*((c + r) % 4)];
      s = t;
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            t[r + 4*c] = gmul(8'h02, s[r + 4*c]) ^ gmul(8'h03, s[(r+1)%4 + 4*c])
                         ^ s[(r+2)%4 + 4*c] ^ s[(r+3)%4 + 4*c];
        s = t;
      end
      kk = rk_model(k, rnd);
      for (int i = 0; i < 16; i++) s[i] ^= 8'(kk >> (8 * (15 - i)));
    end
    out = '0;
    for (int i = 0; i < 16; i++) out = (out << 8) | 128'(s[i]);
    return out;
  endfunction

  function automatic logic [127:0] dec_model(input logic [127:0] ct, input logic [127:0] k);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] kk, out;
    for (int i = 0; i < 16; i++) s[i] = 8'(ct >> (8 * (15 - i)));
    kk = rk_model(k, 10);
    for (int i = 0; i < 16; i++) s[i] ^= 8'(kk >> (8 * (15 - i)));
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r + 4*((c + r) % 4)] = s[r + 4*c];
      s = t;
      for (int i = 0; i < 16; i++) s[i] = isb[s[i]];
      kk = rk_model(k, rnd);
      for (int i = 0; i < 16; i++) s[i] ^= 8'(kk >> (8 * (15 - i)));
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            t[r + 4*c] = gmul(8'h0e, s[r + 4*c]) ^ gmul(8'h0b, s[(r+1)%4 + 4*c])
                         ^ gmul(8'h0d, s[(r+2)%4 + 4*c]) ^ gmul(8'h09, s[(r+3)%4 + 4*c]);
        s = t;
      end
    end
    out = '0;
    for (int i = 0; i < 16; i++) out = (out << 8) | 128'(s[i]);
    return out;
  endfunction

  // ---------------- cycle-level expectation: accept when idle, done 12 edges later ----------------
  logic         m_busy, m_done, m_inflight;
  logic [127:0] m_pt, m_res;
  int           m_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_inflight <= 1'b0; m_pt <= '0; m_res <= '0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_inflight) begin
        if (m_left == 1) begin
          m_inflight <= 1'b0; m_busy <= 1'b0; m_done <= 1'b1; m_pt <= m_res;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (start) begin
        m_inflight <= 1'b1; m_busy <= 1'b1; m_left <= 12;
        m_res <= dec_model(ciphertext, key);
      end
    end
  end

  // Every cycle: outputs against the model; on done, result against the driver's expectation
  always @(negedge clk) begin
    check("busy", 128'(busy), 128'(m_busy));
    check("done", 128'(done), 128'(m_done));
    check("plaintext", plaintext, m_pt);
    if (done) done_count++;
    if (m_done) begin
      if (exp_q.size() == 0) check("unexpected_result", plaintext, 128'h0);
      else check("result", plaintext, exp_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  task automatic run_block(input string name, input logic [127:0] ct, input logic [127:0] k,
                           input logic [127:0] exp);
    int lat, bcyc;
    exp_q.push_back(exp);
    start = 1'b1; ciphertext = ct; key = k;
    @(posedge clk); #1;
    start = 1'b0;
    ciphertext = {$urandom, $urandom, $urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom};
    lat = 0; bcyc = 0;
    while (!done && lat < 40) begin
      if (busy) bcyc++;
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 128'(lat), 128'(12));
    check({name, "_busy_cycles"}, 128'(bcyc), 128'(12));
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_done_seen"}, 128'(done), 128'(1));
  endtask

  initial begin
    int dc0;
    time t1, t2;
    logic [127:0] pt, k;

    build_tables();
    check("model_sbox_00", 128'(sb[8'h00]), 128'h63);
    check("model_sbox_53", 128'(sb[8'h53]), 128'hed);
    check("model_isbox_63", 128'(isb[8'h63]), 128'h00);
    check("model_enc_c1", enc_model(C1_PT, C1_KEY), C1_CT);
    check("model_dec_c1", dec_model(C1_CT, C1_KEY), C1_PT);
    check("model_enc_b", enc_model(B_PT, B_KEY), B_CT);
    check("model_dec_b", dec_model(B_CT, B_KEY), B_PT);

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_done", 128'(done), 128'(0));
    check("reset_plaintext", plaintext, 128'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_block("c1", C1_CT, C1_KEY, C1_PT);
    check("c1_held_plaintext", plaintext, C1_PT);
    run_block("appb", B_CT, B_KEY, B_PT);

    // start while busy is ignored
    dc0 = done_count;
    exp_q.push_back(C1_PT);
    start = 1'b1; ciphertext = C1_CT; key = C1_KEY;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; ciphertext = B_CT; key = B_KEY;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignored");
    check("ignored_result", plaintext, C1_PT);
    repeat (15) begin @(posedge clk); #1; end
    check("ignored_done_pulses", 128'(done_count - dc0), 128'(1));

    // start held across two completions
    exp_q.push_back(C1_PT);
    exp_q.push_back(B_PT);
    start = 1'b1; ciphertext = C1_CT; key = C1_KEY;
    @(posedge clk); #1;
    wait_done("held_first");
    t1 = $time;
    ciphertext = B_CT; key = B_KEY;
    @(posedge clk); #1;
    wait_done("held_second");
    t2 = $time;
    start = 1'b0;
    check("held_spacing", 128'((t2 - t1) / 10), 128'(13));
    check("held_second_result", plaintext, B_PT);
    repeat (3) begin @(posedge clk); #1; end

    // reset mid-operation aborts without a done pulse
    dc0 = done_count;
    exp_q.push_back(C1_PT);
    start = 1'b1; ciphertext = C1_CT; key = C1_KEY;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_plaintext", plaintext, 128'h0);
    repeat (2) begin @(posedge clk); #1; end
    check("abort_done", 128'(done), 128'(0));
    rst = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    check("abort_no_done", 128'(done_count - dc0), 128'(0));
    run_block("after_abort", C1_CT, C1_KEY, C1_PT);

    // random round trip through the reference encryptor
    for (int n = 0; n < 1000; n++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      k  = {$urandom, $urandom, $urandom, $urandom};
      run_block("loopback", enc_model(pt, k), k, pt);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) begin @(posedge clk); #1; end
    check("results_outstanding", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
